// File: rtl/lab3_keypad_scanner.sv
// Column-scan controller for a 4x4 active-low matrix keypad.
// It synchronizes the rows, debounces press and release, and latches a {rows,cols} code for the key decoder.
module lab3_keypad_scanner #(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [7:0] keypress,
    output logic       key_valid,
    output logic       held
);

    localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    // Handshake: key_valid is a single-cycle strobe with no ready; keypress
    // is stable from the latch until the next latch, so it may be sampled
    // on the strobe cycle or any time while held is high.
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    rows_m;
    logic [3:0]    rows_s;
    logic [3:0]    prow;
    logic [3:0]    low;
    logic [1:0]    col_idx;
    logic [CW-1:0] cnt;
    logic          one_low;
    logic          key_up;
    logic          cnt_clr;
    logic          col_adv;
    logic          latch;
    logic          fire;
    logic          release_done;

    assign low     = ~rows_s;
    assign one_low = (low != 4'b0000) && ((low & (low - 4'd1)) == 4'b0000);
    // The latched row bit has gone high; other rows are don't-care here.
    assign key_up  = &(rows_s | prow);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SCAN: begin
                if (cnt == SCAN_LAST && one_low) state_next = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (rows_s != prow)       state_next = SCAN;
                else if (cnt == DEB_LAST) state_next = HELD;
            end
            HELD: begin
                if (key_up) state_next = RELEASE;
            end
            RELEASE: begin
                if (!key_up)              state_next = HELD;
                else if (cnt == DEB_LAST) state_next = SCAN;
            end
            default: state_next = SCAN;
        endcase
    end

    always_comb begin
        cols         = ~(4'b0001 << col_idx);
        cnt_clr      = 1'b0;
        col_adv      = 1'b0;
        latch        = 1'b0;
        fire         = 1'b0;
        release_done = 1'b0;
        case (state)
            SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_clr = 1'b1;
                    latch   = one_low;
                    col_adv = !one_low;
                end
            end
            DEBOUNCE: begin
                if (rows_s != prow) begin
                    cnt_clr = 1'b1;
                    col_adv = 1'b1;
                end else if (cnt == DEB_LAST) begin
                    cnt_clr = 1'b1;
                    fire    = 1'b1;
                end
            end
            HELD: begin
                cnt_clr = 1'b1;
            end
            RELEASE: begin
                if (!key_up) begin
                    cnt_clr = 1'b1;
                end else if (cnt == DEB_LAST) begin
                    cnt_clr      = 1'b1;
                    col_adv      = 1'b1;
                    release_done = 1'b1;
                end
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_m    <= 4'b1111;
            rows_s    <= 4'b1111;
            prow      <= 4'b1111;
            col_idx   <= 2'd0;
            cnt       <= '0;
            keypress  <= 8'hFF;
            key_valid <= 1'b0;
            held      <= 1'b0;
        end else begin
            rows_m    <= rows;
            rows_s    <= rows_m;
            key_valid <= fire;
            if (cnt_clr) cnt <= '0;
            else         cnt <= cnt + CW'(1);
            if (col_adv) col_idx <= col_idx + 2'd1;
            if (latch) begin
                prow     <= rows_s;
                keypress <= {rows_s, cols};
            end
            if (fire)              held <= 1'b1;
            else if (release_done) held <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lab3_keypad_scanner.sv
// Bench for lab3_keypad_scanner: a physical keypad model drives rows from cols, and a scoreboard
// checks each key_valid strobe against the expected key code, with directed checks for timing and reset.
module tb_lab3_keypad_scanner;

    localparam int SC = 4;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [7:0] keypress;
    logic       key_valid;
    logic       held;

    lab3_keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .keypress(keypress), .key_valid(key_valid), .held(held)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    logic kv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad: a pressed key pulls its row low only while its column is driven low.
    logic k1_on = 1'b0, k2_on = 1'b0;
    int   k1_r = 0, k1_c = 0, k2_r = 0, k2_c = 0;
    always_comb begin
        rows = 4'hF;
        if (k1_on && !cols[k1_c]) rows[k1_r] = 1'b0;
        if (k2_on && !cols[k2_c]) rows[k2_r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] key_code(input int r, input int c);
        logic [3:0] rr, cc;
        rr = 4'hF; rr[r] = 1'b0;
        cc = 4'hF; cc[c] = 1'b0;
        return {rr, cc};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_kp(input logic [7:0] v, input string nm);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (keypress == v) break;
        end
        check(nm, keypress, v);
    endtask

    task automatic wait_held(input logic v, input string nm);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (held == v) break;
        end
        check(nm, held, v);
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, " cols"}, cols, 4'b1110);
        check({nm, " keypress"}, keypress, 8'hFF);
        check({nm, " key_valid"}, key_valid, 1'b0);
        check({nm, " held"}, held, 1'b0);
    endtask

    // Monitor: every strobe must match the oldest expected key, and last one cycle.
    always @(negedge clk) begin
        if (reset && key_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_key_valid: got keypress %0h, required no strobe (t=%0t)", keypress, $time);
            end else begin
                check("strobe_code", keypress, exp_q.pop_front());
                check("strobe_held", held, 1'b1);
            end
            if (kv_prev) begin
                n_cmp++; n_bad++;
                $display("FAIL strobe_width: got key_valid high 2 cycles, required 1 (t=%0t)", $time);
            end
        end
        kv_prev = reset && key_valid;
    end

    initial begin
        int t0;
        logic [3:0] ec;
        logic [7:0] code;

        // Reset values while held in reset
        tick(3);
        check_reset_vals("reset");
        reset = 1'b1;

        // Idle scan: column advances every SC cycles
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            ec = 4'hF;
            ec[(k / SC) % 4] = 1'b0;
            check("idle_cols", cols, ec);
        end

        // Row2/col1 press: latch-to-strobe latency and frozen columns
        k1_r = 2; k1_c = 1; k1_on = 1'b1;
        exp_q.push_back(key_code(2, 1));
        wait_kp(8'hBD, "latch_code");
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (key_valid) break;
        end
        check("strobe_latency", cyc - t0, DC);
        @(negedge clk);
        check("strobe_cleared", key_valid, 1'b0);
        tick(6);
        check("held_frozen_cols", cols, 4'b1101);
        check("held_flag", held, 1'b1);

        // Release glitch shorter than the debounce window
        k1_on = 1'b0;
        tick(2);
        k1_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("held_through_glitch", held, 1'b1);
        end
        // Second key in the same column while held
        k2_r = 0; k2_c = 1; k2_on = 1'b1;
        tick(10);
        check("second_key_held", held, 1'b1);
        check("second_key_code", keypress, 8'hBD);
        k1_on = 1'b0; k2_on = 1'b0;
        wait_held(1'b0, "release_done");
        check("release_next_col", cols, 4'b1011);
        tick(10);

        // Bounce: released right at the latch, debounce must abort
        @(negedge clk); #2 reset = 1'b0;
        #1 check("pulse_reset_kp", keypress, 8'hFF);
        @(negedge clk) reset = 1'b1;
        k1_r = 2; k1_c = 1; k1_on = 1'b1;
        wait_kp(8'hBD, "bounce_latch");
        k1_on = 1'b0;
        tick(3);
        check("bounce_resume_cols", cols, 4'b1011);
        check("bounce_held", held, 1'b0);
        tick(20);

        // Asynchronous reset in HELD, then in DEBOUNCE
        k1_r = 1; k1_c = 3; k1_on = 1'b1;
        code = key_code(1, 3);
        exp_q.push_back(code);
        wait_held(1'b1, "pre_reset_held");
        tick(2);
        #2 reset = 1'b0;
        #1 check_reset_vals("reset_in_held");
        @(negedge clk) reset = 1'b1;
        wait_kp(code, "relatch_code");
        #2 reset = 1'b0;
        #1 check_reset_vals("reset_in_debounce");
        exp_q.push_back(code);
        @(negedge clk) reset = 1'b1;
        wait_held(1'b1, "post_reset_held");
        tick(3);
        k1_on = 1'b0;
        tick(20);
        check("post_reset_release", held, 1'b0);

        // Randomized presses, bounces, release glitches and extra keys
        for (int n = 0; n < 30; n++) begin
            int r, c, len, gl;
            bit good;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            good = ($urandom_range(0, 2) != 0);
            k1_r = r; k1_c = c;
            if (good) begin
                exp_q.push_back(key_code(r, c));
                len = $urandom_range(40, 60);
                gl = $urandom_range(0, 3);
                k1_on = 1'b1;
                for (int i = 0; i < len; i++) begin
                    @(negedge clk);
                    if (i == 32 && $urandom_range(0, 1) == 1) begin
                        k2_r = (r + 1 + $urandom_range(0, 2)) % 4;
                        k2_c = $urandom_range(0, 3);
                        k2_on = 1'b1;
                    end
                    k1_on = !(i >= 34 && i < 34 + gl);
                end
                check("rand_hold_code", keypress, key_code(r, c));
                k1_on = 1'b0; k2_on = 1'b0;
            end else begin
                k1_on = 1'b1;
                tick($urandom_range(1, 4));
                k1_on = 1'b0;
            end
            tick(20);
            check("rand_idle_held", held, 1'b0);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lab3_keypad_scanner.md
Name: lab3_keypad_scanner

Overview:
- Scan controller for the 4x4 matrix keypad that feeds the lab 3 key decoder.
- Drives the column lines one at a time (active-low) and samples the synchronized row lines.
- Debounces both press and release.
- Presents a stable 8-bit {rows,cols} keypress code to the decoder, plus a one-cycle key_valid strobe per accepted press.

Parameters:
- SCAN_CYCLES, 1000: clock cycles each column is driven before rows are sampled; must be >= 3 to cover synchronizer latency.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a press or a release; must be >= 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rows  in  4  raw keypad row inputs, active-low (pulled up), asynchronous to clk.
- cols  out  4  column drive, active-low one-hot.
- keypress  out  8  latched {rows_sync[3:0], cols[3:0]} of the accepted key; input to the decoder.
- key_valid  out  1  single-cycle pulse when a press is accepted.
- held  out  1  high while an accepted key is held (through release debounce).

Behaviour:
- Reset (reset=0, asynchronous): state=SCAN, col_idx=0, cols=4'b1110, keypress=8'hFF, key_valid=0, held=0, all counters=0, synchronizer flops=4'b1111.
- Synchronizer: rows passes through 2 flops to give rows_s. All decisions use rows_s only.
- Column drive: cols=~(4'b0001<<col_idx). col_idx wraps 3->0.
- SCAN:
  - dwell counter runs 0..SCAN_CYCLES-1; rows_s is sampled on the cycle where count==SCAN_CYCLES-1.
  - Exactly one bit of rows_s low: latch row pattern prow=rows_s and keypress={rows_s,cols}; go to DEBOUNCE with the debounce counter cleared; cols frozen.
  - rows_s==4'b1111, or more than one row low: col_idx++, dwell counter cleared.
- DEBOUNCE:
  - counter increments each cycle while rows_s==prow.
  - Any cycle with rows_s!=prow: abort to SCAN with col_idx++; keypress keeps its old value, no pulse.
  - Counter reaches DEBOUNCE_CYCLES-1 with rows_s==prow: next cycle key_valid=1 for exactly one cycle, held=1, state=HELD.
  - keypress changes only at the SCAN->DEBOUNCE latch. The decoder sees a stable code for at least DEBOUNCE_CYCLES cycles before key_valid.
- HELD:
  - cols frozen.
  - Stays while the latched row bit in rows_s is low. Other rows/keys are ignored (no second press, keypress unchanged).
  - When the latched row bit goes high: go to RELEASE with the counter cleared.
- RELEASE:
  - counter increments while the latched row bit is high.
  - Row goes low again before DEBOUNCE_CYCLES: return to HELD; no new key_valid; held stays 1.
  - DEBOUNCE_CYCLES consecutive high cycles: held=0, col_idx++, go to SCAN with the dwell counter cleared.
- key_valid is never asserted outside the DEBOUNCE->HELD transition. At most one pulse per physical press.
- Reset asserted in any state forces reset values immediately, including mid-pulse and mid-debounce.
- Counters are sized ceil(log2(max(SCAN_CYCLES,DEBOUNCE_CYCLES)+1)) and never wrap within a state.

Test Plan:
- Bench parameters for all cases: SCAN_CYCLES=4, DEBOUNCE_CYCLES=4.
1. Hold reset=0, then release it -> cols=1110, keypress=8'hFF, key_valid=0, held=0 during reset; scanning starts on the first edge after release.
2. rows=1111 for 32 cycles -> cols sequence 1110,1101,1011,0111,1110 (4 cycles each); key_valid never 1.
3. Drive rows=1011 whenever cols=1101 (row2/col1), held steady -> keypress=8'b1011_1101; cols frozen at 1101; key_valid high exactly one cycle, 4 cycles after the latch; held=1; decoder output matches the expected key.
4. Press bounce: rows=1011 for 2 cycles after the latch, then 1111 -> no key_valid; keypress unchanged from before; scanning resumes at cols=1011.
5. From HELD:
   - rows=1111 for 2 cycles, then 1011 -> held stays 1, no second pulse.
   - then rows=1111 for >=4 cycles -> held=0; cols advances to 1011.
   - while held, also drive a second row low -> ignored.
6. Assert reset=0 in HELD and in DEBOUNCE -> all outputs return to reset values asynchronously; the next press after release is accepted normally with one key_valid.
